// File: rtl/shifter_v4_core_if.sv
// Control/status bundle between the shifter_v4 register slave and its shift engine.
// The slave drives the request side; the core drives the status side.
interface shifter_v4_core_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = 16
);
   localparam int unsigned AMT_WIDTH = $clog2(DATA_WIDTH);

   logic                  start;
   logic                  abort;
   logic                  dir;
   logic [1:0]            mode;
   logic [DATA_WIDTH-1:0] data_in;
   logic [AMT_WIDTH-1:0]  amount;
   logic                  busy;
   logic                  done;
   logic                  err;
   logic [DATA_WIDTH-1:0] result;
   logic [CNT_WIDTH-1:0]  op_count;

   modport master (
      output start, abort, dir, mode, data_in, amount,
      input  busy, done, err, result, op_count
   );

   modport slave (
      input  start, abort, dir, mode, data_in, amount,
      output busy, done, err, result, op_count
   );
endinterface

// File: rtl/shifter_v4_core.sv
// Iterative shift engine: logical/arithmetic/rotate shifts of up to STEP bits per clock,
// driven by a start/busy/done handshake with abort and a wrapping completed-op counter.
module shifter_v4_core #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned STEP       = 1,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic             ACLK,
   input  logic             ARESET,
   shifter_v4_core_if.slave bus_io
);
   localparam int unsigned AW = $clog2(DATA_WIDTH);
   localparam logic [AW:0] StepW = STEP[AW:0];

   typedef enum logic {StIdle, StShift} state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] work_q, work_d;
   logic [DATA_WIDTH-1:0] result_q, result_d;
   logic [AW-1:0]         rem_q, rem_d;
   logic                  dir_q, dir_d;
   logic [1:0]            mode_q, mode_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

   logic [AW-1:0]         k;
   logic [AW-1:0]         k_inv;
   logic [DATA_WIDTH-1:0] shifted;

   // k = min(STEP, remaining); with STEP == DATA_WIDTH the first branch is never taken.
   always_comb begin
      if ({1'b0, rem_q} > StepW) begin
         k = StepW[AW-1:0];
      end else begin
         k = rem_q;
      end
      k_inv = -k;
   end

   always_comb begin
      shifted = work_q;
      case (mode_q)
         2'b00:   shifted = dir_q ? (work_q >> k) : (work_q << k);
         2'b01:   shifted = dir_q ? $unsigned($signed(work_q) >>> k) : (work_q << k);
         2'b10:   shifted = dir_q ? ((work_q >> k) | (work_q << k_inv))
                                  : ((work_q << k) | (work_q >> k_inv));
         default: shifted = work_q;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      work_d   = work_q;
      result_d = result_q;
      rem_d    = rem_q;
      dir_d    = dir_q;
      mode_d   = mode_q;
      done_d   = 1'b0;
      err_d    = err_q;
      cnt_d    = cnt_q;
      case (state_q)
         StIdle: begin
            if (bus_io.start) begin
               state_d = StShift;
               work_d  = bus_io.data_in;
               rem_d   = bus_io.amount;
               dir_d   = bus_io.dir;
               mode_d  = bus_io.mode;
               err_d   = (bus_io.mode == 2'b11);
            end
         end
         StShift: begin
            if (bus_io.abort) begin
               state_d = StIdle;
            end else if (rem_q != '0) begin
               work_d = shifted;
               rem_d  = rem_q - k;
            end else begin
               state_d  = StIdle;
               result_d = work_q;
               done_d   = 1'b1;
               cnt_d    = cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q  <= StIdle;
         work_q   <= '0;
         result_q <= '0;
         rem_q    <= '0;
         dir_q    <= 1'b0;
         mode_q   <= 2'b00;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         work_q   <= work_d;
         result_q <= result_d;
         rem_q    <= rem_d;
         dir_q    <= dir_d;
         mode_q   <= mode_d;
         done_q   <= done_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus_io.busy     = (state_q == StShift);
   assign bus_io.done     = done_q;
   assign bus_io.err      = err_q;
   assign bus_io.result   = result_q;
   assign bus_io.op_count = cnt_q;
endmodule

// File: tb/tb_shifter_v4_core.sv
// Directed bench: a STEP=1 core for functional vectors, abort and reset, and a STEP=8 core
// with a 4-bit counter for multi-step latency and counter wrap.
module tb_shifter_v4_core;
   logic clk = 1'b0;
   logic rst1 = 1'b1;
   logic rst8 = 1'b1;
   always #5 clk = ~clk;

   shifter_v4_core_if #(.DATA_WIDTH(32), .CNT_WIDTH(16)) if1 ();
   shifter_v4_core_if #(.DATA_WIDTH(32), .CNT_WIDTH(4))  if8 ();

   shifter_v4_core #(.DATA_WIDTH(32), .STEP(1), .CNT_WIDTH(16)) u_dut1 (
      .ACLK   (clk),
      .ARESET (rst1),
      .bus_io (if1)
   );

   shifter_v4_core #(.DATA_WIDTH(32), .STEP(8), .CNT_WIDTH(4)) u_dut8 (
      .ACLK   (clk),
      .ARESET (rst8),
      .bus_io (if8)
   );

   typedef struct {
      logic [1:0]  mode;
      logic        dir;
      logic [31:0] data;
      logic [4:0]  amt;
      logic [31:0] res;
      logic        err;
      int          lat;
   } vec_t;

   vec_t        vecs1[12];
   vec_t        vecs8[2];
   int          n_checks = 0;
   int          n_pass = 0;
   logic [15:0] exp_cnt1 = '0;
   logic [3:0]  exp_cnt8 = '0;
   logic [31:0] last_res1 = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic set_inputs(input bit s, input logic st, input logic ab, input logic [1:0] m,
                             input logic d, input logic [31:0] data, input logic [4:0] amt);
      if (s) begin
         if8.start = st; if8.abort = ab; if8.mode = m; if8.dir = d;
         if8.data_in = data; if8.amount = amt;
      end else begin
         if1.start = st; if1.abort = ab; if1.mode = m; if1.dir = d;
         if1.data_in = data; if1.amount = amt;
      end
   endtask

   function automatic logic rd_busy(input bit s);
      return s ? if8.busy : if1.busy;
   endfunction
   function automatic logic rd_done(input bit s);
      return s ? if8.done : if1.done;
   endfunction
   function automatic logic rd_err(input bit s);
      return s ? if8.err : if1.err;
   endfunction
   function automatic logic [31:0] rd_res(input bit s);
      return s ? if8.result : if1.result;
   endfunction
   function automatic logic [15:0] rd_cnt(input bit s);
      return s ? {12'h000, if8.op_count} : if1.op_count;
   endfunction

   // Called on a falling edge; leaves the bench on the falling edge after done drops.
   task automatic run_op(input bit s, input bit with_abort, input vec_t v, input string name);
      int c;
      bit seen;
      set_inputs(s, 1'b1, with_abort, v.mode, v.dir, v.data, v.amt);
      @(negedge clk);
      // Scramble operands after acceptance; the core must have latched them.
      set_inputs(s, 1'b0, 1'b0, v.mode ^ 2'b01, ~v.dir, ~v.data, ~v.amt);
      check({name, " busy_after_start"}, 64'(rd_busy(s)), 64'd1);
      c = 0;
      seen = 1'b0;
      while (!seen && c < 80) begin
         @(negedge clk);
         c++;
         if (rd_done(s)) seen = 1'b1;
      end
      if (s) exp_cnt8 = exp_cnt8 + 1'b1;
      else exp_cnt1 = exp_cnt1 + 1'b1;
      check({name, " latency"}, seen ? 64'(c) : 64'hFFFF, 64'(v.lat));
      check({name, " result"}, 64'(rd_res(s)), 64'(v.res));
      check({name, " err"}, 64'(rd_err(s)), 64'(v.err));
      check({name, " busy_at_done"}, 64'(rd_busy(s)), 64'd0);
      check({name, " op_count"}, 64'(rd_cnt(s)), s ? 64'(exp_cnt8) : 64'(exp_cnt1));
      @(negedge clk);
      check({name, " done_one_cycle"}, 64'(rd_done(s)), 64'd0);
      if (!s) last_res1 = v.res;
   endtask

   initial begin
      int dones;
      vec_t v;
      vecs1[0]  = '{2'b00, 1'b0, 32'h0000_0001, 5'd4,  32'h0000_0010, 1'b0, 5};
      vecs1[1]  = '{2'b01, 1'b1, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 32};
      vecs1[2]  = '{2'b10, 1'b1, 32'h0000_0001, 5'd1,  32'h8000_0000, 1'b0, 2};
      vecs1[3]  = '{2'b10, 1'b1, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0, 1};
      vecs1[4]  = '{2'b00, 1'b1, 32'hF000_0000, 5'd4,  32'h0F00_0000, 1'b0, 5};
      vecs1[5]  = '{2'b01, 1'b1, 32'h4000_0000, 5'd2,  32'h1000_0000, 1'b0, 3};
      vecs1[6]  = '{2'b01, 1'b0, 32'h8000_0001, 5'd1,  32'h0000_0002, 1'b0, 2};
      vecs1[7]  = '{2'b10, 1'b0, 32'h8000_0001, 5'd4,  32'h0000_0018, 1'b0, 5};
      vecs1[8]  = '{2'b10, 1'b0, 32'h1234_5678, 5'd31, 32'h091A_2B3C, 1'b0, 32};
      vecs1[9]  = '{2'b10, 1'b0, 32'h091A_2B3C, 5'd1,  32'h1234_5678, 1'b0, 2};
      vecs1[10] = '{2'b11, 1'b0, 32'h1234_5678, 5'd3,  32'h1234_5678, 1'b1, 4};
      vecs1[11] = '{2'b00, 1'b0, 32'h0000_00A5, 5'd8,  32'h0000_A500, 1'b0, 9};
      vecs8[0]  = '{2'b01, 1'b1, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 5};
      vecs8[1]  = '{2'b10, 1'b1, 32'h0000_ABCD, 5'd12, 32'hBCD0_000A, 1'b0, 3};

      set_inputs(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 5'd0);
      set_inputs(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 5'd0);
      repeat (2) @(negedge clk);
      rst1 = 1'b0;
      rst8 = 1'b0;
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         check("reset busy", 64'(rd_busy(s[0])), 64'd0);
         check("reset done", 64'(rd_done(s[0])), 64'd0);
         check("reset err", 64'(rd_err(s[0])), 64'd0);
         check("reset result", 64'(rd_res(s[0])), 64'd0);
         check("reset op_count", 64'(rd_cnt(s[0])), 64'd0);
      end

      for (int i = 0; i < 12; i++) run_op(1'b0, 1'b0, vecs1[i], $sformatf("vec1_%0d", i));
      for (int i = 0; i < 2; i++) run_op(1'b1, 1'b0, vecs8[i], $sformatf("vec8_%0d", i));

      // Abort mid-shift, with an ignored second start beforehand.
      set_inputs(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0001, 5'd20);
      @(negedge clk);
      if1.start = 1'b0;
      dones = 0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (if1.done) dones++;
         if (c == 3) begin if1.start = 1'b1; if1.data_in = 32'hFFFF_FFFF; end
         if (c == 4) if1.start = 1'b0;
         if (c == 5) if1.abort = 1'b1;
         if (c == 6) begin
            check("abort busy_low", 64'(if1.busy), 64'd0);
            if1.abort = 1'b0;
         end
      end
      repeat (30) begin
         @(negedge clk);
         if (if1.done) dones++;
      end
      check("abort no_done", 64'(dones), 64'd0);
      check("abort result_kept", 64'(if1.result), 64'(last_res1));
      check("abort op_count_kept", 64'(if1.op_count), 64'(exp_cnt1));
      check("abort err_kept", 64'(if1.err), 64'd0);
      v = '{2'b00, 1'b0, 32'h0000_0003, 5'd2, 32'h0000_000C, 1'b0, 3};
      run_op(1'b0, 1'b0, v, "after_abort");
      // Start and abort together in IDLE: start wins.
      v = '{2'b00, 1'b1, 32'h0000_0100, 5'd4, 32'h0000_0010, 1'b0, 5};
      run_op(1'b0, 1'b1, v, "start_with_abort");

      // Asynchronous reset mid-shift.
      set_inputs(1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0001, 5'd20);
      @(negedge clk);
      if1.start = 1'b0;
      repeat (3) @(negedge clk);
      check("midreset busy_before", 64'(if1.busy), 64'd1);
      rst1 = 1'b1;
      #1;
      check("midreset busy", 64'(if1.busy), 64'd0);
      check("midreset done", 64'(if1.done), 64'd0);
      check("midreset err", 64'(if1.err), 64'd0);
      check("midreset result", 64'(if1.result), 64'd0);
      check("midreset op_count", 64'(if1.op_count), 64'd0);
      @(negedge clk);
      rst1 = 1'b0;
      exp_cnt1 = '0;
      dones = 0;
      repeat (25) begin
         @(negedge clk);
         if (if1.done || if1.busy) dones++;
      end
      check("midreset no_done", 64'(dones), 64'd0);
      v = '{2'b00, 1'b0, 32'h0000_0001, 5'd4, 32'h0000_0010, 1'b0, 5};
      run_op(1'b0, 1'b0, v, "after_reset");

      // 4-bit counter on the STEP=8 core reaches 16 ops and wraps to 0.
      for (int i = 0; i < 14; i++) begin
         v = '{2'b00, 1'b0, 32'(i + 7), 5'd0, 32'(i + 7), 1'b0, 1};
         run_op(1'b1, 1'b0, v, $sformatf("wrap_%0d", i));
      end
      check("wrap final_zero", 64'(if8.op_count), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
